// File: rtl/vai_pkg.sv
// Shared types and constants for the VAI transmit auditor: CCI-P c0/c1 request
// structs, the auditor state enum, the 42-bit cache-line address width, the
// bounds window (VAI_WINDOW_BITS), and the address rebase helper.
package vai_pkg;

  localparam int VAI_ADDR_WIDTH  = 42;
  localparam int VAI_WINDOW_BITS = 30;

  typedef logic [VAI_ADDR_WIDTH-1:0] t_ccip_clAddr;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FENCE = 2'd1,
    ST_HELD  = 2'd2
  } vai_state_e;

  // c0 (read) request header
  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    logic [1:0]   cl_len;
    logic [3:0]   req_type;
    logic [1:0]   rsvd0;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  // c1 (write) request header
  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    logic [1:0]   cl_len;
    logic [3:0]   req_type;
    logic [1:0]   rsvd0;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  // Sub-AFU addresses are relative to its window; the mux sees absolute
  // addresses. The sum wraps modulo 2^42 by construction.
  function automatic t_ccip_clAddr vai_rebase(input t_ccip_clAddr addr,
                                              input t_ccip_clAddr off);
    return addr + off;
  endfunction

endpackage

// File: rtl/vai_tx_auditor_if.sv
// Bundle of the auditor's request/response paths between a sub-AFU and the mux.
// Ports: afu_c0Tx/afu_c1Tx requests in, rx_c0_rsp/rx_c1_rsp response strobes in,
//        mux_c0Tx/mux_c1Tx audited requests out (slave = auditor side).
interface vai_tx_auditor_if;
  import vai_pkg::*;

  t_if_ccip_c0_Tx afu_c0Tx;
  t_if_ccip_c1_Tx afu_c1Tx;
  t_if_ccip_c0_Tx mux_c0Tx;
  t_if_ccip_c1_Tx mux_c1Tx;
  logic           rx_c0_rsp;
  logic           rx_c1_rsp;

  modport master (
    output afu_c0Tx, afu_c1Tx, rx_c0_rsp, rx_c1_rsp,
    input  mux_c0Tx, mux_c1Tx
  );

  modport slave (
    input  afu_c0Tx, afu_c1Tx, rx_c0_rsp, rx_c1_rsp,
    output mux_c0Tx, mux_c1Tx
  );

endinterface

// File: rtl/vai_outstanding_cnt.sv
// Outstanding-request counter for one CCI-P channel; count updates one cycle after inc/dec.
// No backpressure: saturates at all-ones and holds at zero, flagging err combinationally.
// Ports: clk, reset, inc (request emitted), dec (response seen), count, err.
module vai_outstanding_cnt #(
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // A simultaneous inc and dec cancel, so only the lone cases can misbehave.
  always_comb begin
    err = 1'b0;
    if (inc && !dec && (count == CNT_MAX)) err = 1'b1;
    if (dec && !inc && (count == '0))      err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vai_tx_auditor.sv
// Audits and rebases one sub-AFU's CCI-P requests; accepted requests appear on mux_* one cycle later.
// No backpressure: while fenced/held (or out of window) requests are dropped, never stalled.
// Ports: clk, reset, sub_afu_reset, offset, tx (slave modport), quiesced, audit_err, drop_cnt.
// Optional: define VAI_AUDIT_BOUNDS_EN to drop requests outside the 2^VAI_WINDOW_BITS window.
module vai_tx_auditor
  import vai_pkg::*;
#(
  parameter int CNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sub_afu_reset,
  input  logic [63:0]            offset,
  vai_tx_auditor_if.slave        tx,
  output logic                   quiesced,
  output logic                   audit_err,
  output logic [31:0]            drop_cnt
);

  vai_state_e         state;
  logic               state_run;
  logic               c0_oob, c1_oob;
  logic               c0_acc, c1_acc;
  logic               c0_drop, c1_drop;
  logic               c0_err, c1_err;
  logic [CNT_WIDTH-1:0] c0_count, c1_count;
  t_ccip_c0_ReqMemHdr c0_hdr;
  t_ccip_c1_ReqMemHdr c1_hdr;
  t_if_ccip_c0_Tx     c0_q;
  t_if_ccip_c1_Tx     c1_q;

  // Only the low 42 offset bits form a cache-line address.
  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[63:VAI_ADDR_WIDTH];

`ifdef VAI_AUDIT_BOUNDS_EN
  assign c0_oob = tx.afu_c0Tx.valid &&
                  (tx.afu_c0Tx.hdr.address[VAI_ADDR_WIDTH-1:VAI_WINDOW_BITS] != '0);
  assign c1_oob = tx.afu_c1Tx.valid &&
                  (tx.afu_c1Tx.hdr.address[VAI_ADDR_WIDTH-1:VAI_WINDOW_BITS] != '0);
`else
  assign c0_oob = 1'b0;
  assign c1_oob = 1'b0;
`endif

  // The cycle sub_afu_reset is first seen we are still in RUN, so a request
  // in that cycle passes; the fence applies from the next cycle on.
  assign state_run = (state == ST_RUN);
  assign c0_acc    = tx.afu_c0Tx.valid && state_run && !c0_oob;
  assign c1_acc    = tx.afu_c1Tx.valid && state_run && !c1_oob;
  // Only fence drops are counted; bounds drops are reported via audit_err.
  assign c0_drop   = tx.afu_c0Tx.valid && !state_run;
  assign c1_drop   = tx.afu_c1Tx.valid && !state_run;

  // Rebase uses the offset sampled alongside the request, so an offset
  // update applies to the very next request without stalling.
  always_comb begin
    c0_hdr         = tx.afu_c0Tx.hdr;
    c0_hdr.address = vai_rebase(tx.afu_c0Tx.hdr.address, offset[VAI_ADDR_WIDTH-1:0]);
    c1_hdr         = tx.afu_c1Tx.hdr;
    c1_hdr.address = vai_rebase(tx.afu_c1Tx.hdr.address, offset[VAI_ADDR_WIDTH-1:0]);
  end

  // Header/data need no reset: they are ignored unless valid is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_q.valid <= 1'b0;
      c1_q.valid <= 1'b0;
    end else begin
      c0_q.valid <= c0_acc;
      c1_q.valid <= c1_acc;
    end
    c0_q.hdr  <= c0_hdr;
    c1_q.hdr  <= c1_hdr;
    c1_q.data <= tx.afu_c1Tx.data;
  end

  assign tx.mux_c0Tx = c0_q;
  assign tx.mux_c1Tx = c1_q;

  vai_outstanding_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_c0 (
    .clk   (clk),
    .reset (reset),
    .inc   (c0_acc),
    .dec   (tx.rx_c0_rsp),
    .count (c0_count),
    .err   (c0_err)
  );

  vai_outstanding_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_c1 (
    .clk   (clk),
    .reset (reset),
    .inc   (c1_acc),
    .dec   (tx.rx_c1_rsp),
    .count (c1_count),
    .err   (c1_err)
  );

  // Quiesce FSM; quiesced is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      quiesced <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          quiesced <= 1'b0;
          if (sub_afu_reset) state <= ST_FENCE;
        end
        ST_FENCE: begin
          // Wait for every emitted request to be answered before HELD,
          // regardless of whether sub_afu_reset is still asserted.
          if ((c0_count == '0) && (c1_count == '0)) begin
            state    <= ST_HELD;
            quiesced <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!sub_afu_reset) begin
            state    <= ST_RUN;
            quiesced <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          quiesced <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      audit_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      audit_err <= audit_err | c0_err | c1_err | c0_oob | c1_oob;
      drop_cnt  <= drop_cnt + 32'(c0_drop) + 32'(c1_drop);
    end
  end

endmodule

// File: tb/tb_vai_tx_auditor.sv
// Self-checking bench for vai_tx_auditor: scoreboard of expected mux requests,
// plus a small counter/drop/error model updated every clock.
module tb_vai_tx_auditor;
  import vai_pkg::*;

  localparam int M_PASS  = 0;
  localparam int M_FENCE = 1;
  localparam int M_OOB   = 2;
  localparam int M_NONE  = 3;
`ifdef VAI_AUDIT_BOUNDS_EN
  localparam int M_BND = M_OOB;
`else
  localparam int M_BND = M_PASS;
`endif

  typedef struct {
    logic [41:0] addr;
    logic [15:0] mdata;
    logic [3:0]  rt;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sub_afu_reset;
  logic [63:0] offset;
  logic        quiesced;
  logic        audit_err;
  logic [31:0] drop_cnt;

  vai_tx_auditor_if tx ();

  vai_tx_auditor #(.CNT_WIDTH(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .sub_afu_reset (sub_afu_reset),
    .offset        (offset),
    .tx            (tx),
    .quiesced      (quiesced),
    .audit_err     (audit_err),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // model state
  bit          p0, p1, d0, d1, o0, o1;
  logic [9:0]  m_cnt0, m_cnt1;
  bit          m_err;
  logic [31:0] m_drop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] cnt_next(input logic [9:0] c, input bit up, input bit dn);
    if (up && !dn) return (c == 10'h3FF) ? c : c + 10'd1;
    if (dn && !up) return (c == 10'h000) ? c : c - 10'd1;
    return c;
  endfunction

  function automatic bit cnt_bad(input logic [9:0] c, input bit up, input bit dn);
    return (up && !dn && c == 10'h3FF) || (dn && !up && c == 10'h000);
  endfunction

  task automatic model_update();
    if (reset) begin
      m_cnt0 = '0; m_cnt1 = '0; m_err = 0; m_drop = '0;
    end else begin
      m_err  = m_err | cnt_bad(m_cnt0, p0, tx.rx_c0_rsp) | cnt_bad(m_cnt1, p1, tx.rx_c1_rsp) | o0 | o1;
      m_cnt0 = cnt_next(m_cnt0, p0, tx.rx_c0_rsp);
      m_cnt1 = cnt_next(m_cnt1, p1, tx.rx_c1_rsp);
      m_drop = m_drop + 32'(d0) + 32'(d1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    tx.afu_c0Tx.valid = 1'b0;
    tx.afu_c1Tx.valid = 1'b0;
    tx.rx_c0_rsp = 1'b0;
    tx.rx_c1_rsp = 1'b0;
    p0 = 0; p1 = 0; d0 = 0; d1 = 0; o0 = 0; o1 = 0;
  endtask

  task automatic drive_c0(input logic [41:0] a, input logic [15:0] m, input int mode);
    exp_t e;
    tx.afu_c0Tx.hdr = '0;
    tx.afu_c0Tx.hdr.address  = a;
    tx.afu_c0Tx.hdr.mdata    = m;
    tx.afu_c0Tx.hdr.req_type = m[3:0];
    tx.afu_c0Tx.valid = 1'b1;
    p0 = (mode == M_PASS); d0 = (mode == M_FENCE); o0 = (mode == M_OOB);
    if (mode == M_PASS) begin
      e.addr = a + offset[41:0]; e.mdata = m; e.rt = m[3:0]; e.data = '0;
      q0.push_back(e);
    end
  endtask

  task automatic drive_c1(input logic [41:0] a, input logic [15:0] m, input logic [63:0] d, input int mode);
    exp_t e;
    tx.afu_c1Tx.hdr = '0;
    tx.afu_c1Tx.hdr.address  = a;
    tx.afu_c1Tx.hdr.mdata    = m;
    tx.afu_c1Tx.hdr.req_type = m[7:4];
    tx.afu_c1Tx.data  = {8{d}};
    tx.afu_c1Tx.valid = 1'b1;
    p1 = (mode == M_PASS); d1 = (mode == M_FENCE); o1 = (mode == M_OOB);
    if (mode == M_PASS) begin
      e.addr = a + offset[41:0]; e.mdata = m; e.rt = m[7:4]; e.data = d;
      q1.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt0"}, 64'(dut.u_cnt_c0.count), 64'(m_cnt0));
    chk({tag, "_cnt1"}, 64'(dut.u_cnt_c1.count), 64'(m_cnt1));
    chk({tag, "_err"},  64'(audit_err), 64'(m_err));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  // Scoreboard: every valid on the mux side must match the oldest expectation.
  always @(negedge clk) begin
    if (tx.mux_c0Tx.valid === 1'b1) begin
      if (q0.size() == 0) chk("c0_unexpected", 64'(tx.mux_c0Tx.valid), 64'd0);
      else begin
        e0 = q0.pop_front();
        chk("c0_addr",  64'(tx.mux_c0Tx.hdr.address), 64'(e0.addr));
        chk("c0_mdata", 64'(tx.mux_c0Tx.hdr.mdata), 64'(e0.mdata));
        chk("c0_rtype", 64'(tx.mux_c0Tx.hdr.req_type), 64'(e0.rt));
      end
    end
    if (tx.mux_c1Tx.valid === 1'b1) begin
      if (q1.size() == 0) chk("c1_unexpected", 64'(tx.mux_c1Tx.valid), 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("c1_addr",  64'(tx.mux_c1Tx.hdr.address), 64'(e1.addr));
        chk("c1_mdata", 64'(tx.mux_c1Tx.hdr.mdata), 64'(e1.mdata));
        chk("c1_data",  tx.mux_c1Tx.data[63:0], e1.data);
        chk("c1_dtop",  tx.mux_c1Tx.data[511:448], e1.data);
      end
    end
  end

  initial begin
    reset = 1'b1; sub_afu_reset = 1'b0; offset = '0;
    tx.afu_c0Tx = '0; tx.afu_c1Tx = '0;
    idle();
    step(); step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_v0",   64'(tx.mux_c0Tx.valid), 64'd0);
    chk("rst_v1",   64'(tx.mux_c1Tx.valid), 64'd0);
    chk("rst_q",    64'(quiesced), 64'd0);
    chk("rst_st",   64'(dut.state), 64'(ST_RUN));
    check_model("rst");

    // basic rebase with one-cycle latency
    offset = 64'h1000;
    drive_c0(42'h20, 16'hA5C3, M_PASS);
    step(); idle();
    @(negedge clk);
    chk("lat_v0", 64'(tx.mux_c0Tx.valid), 64'd1);
    chk("lat_a0", 64'(tx.mux_c0Tx.hdr.address), 64'h1020);
    step();
    @(negedge clk);
    chk("idle_v0", 64'(tx.mux_c0Tx.valid), 64'd0);

    // address wrap
    offset = 64'h1;
    drive_c0(42'h3FF_FFFF_FFFF, 16'h0055, M_PASS);
    step(); idle();

    // offset change applies to the very next request; c1 alongside
    offset = 64'h100;
    drive_c0(42'h10, 16'h0001, M_PASS);
    step();
    offset = 64'hFFFF_F000_0000_0200; // upper bits ignored
    drive_c0(42'h10, 16'h0002, M_PASS);
    drive_c1(42'h80, 16'h0077, 64'hDEAD_BEEF_0123_4567, M_PASS);
    step(); idle();
    step();
    @(negedge clk);
    check_model("load");

    // drain to c0=1, c1=0
    tx.rx_c0_rsp = 1'b1; tx.rx_c1_rsp = 1'b1;
    step(); tx.rx_c1_rsp = 1'b0;
    step(); step(); idle();
    @(negedge clk);
    check_model("drain");
    // simultaneous emit and response at count 1
    drive_c0(42'h44, 16'h0444, M_PASS);
    tx.rx_c0_rsp = 1'b1;
    step(); idle();
    @(negedge clk);
    chk("same_cnt0", 64'(dut.u_cnt_c0.count), 64'd1);
    tx.rx_c0_rsp = 1'b1; step(); idle();
    @(negedge clk);
    chk("pre_uf_err", 64'(audit_err), 64'd0);
    tx.rx_c0_rsp = 1'b1; step(); idle();
    @(negedge clk);
    chk("uf_err", 64'(audit_err), 64'd1);
    check_model("uf");

    // reset with requests in flight
    offset = 64'h40;
    drive_c0(42'h8, 16'h0808, M_PASS);
    step();
    reset = 1'b1;
    drive_c0(42'h9, 16'h0909, M_NONE);
    drive_c1(42'h9, 16'h0909, 64'h9, M_NONE);
    step(); idle(); reset = 1'b0;
    @(negedge clk);
    chk("rst2_v0", 64'(tx.mux_c0Tx.valid), 64'd0);
    chk("rst2_v1", 64'(tx.mux_c1Tx.valid), 64'd0);
    chk("rst2_q",  64'(quiesced), 64'd0);
    check_model("rst2");

    // fence sequence: third read coincides with sub_afu_reset and still passes
    drive_c0(42'h100, 16'h0100, M_PASS); step();
    drive_c0(42'h101, 16'h0101, M_PASS); step();
    drive_c0(42'h102, 16'h0102, M_PASS); sub_afu_reset = 1'b1; step(); idle();
    @(negedge clk);
    chk("fence_st", 64'(dut.state), 64'(ST_FENCE));
    drive_c0(42'h103, 16'h0103, M_FENCE); step();
    drive_c0(42'h104, 16'h0104, M_FENCE); step(); idle();
    @(negedge clk);
    chk("fence_q", 64'(quiesced), 64'd0);
    check_model("fence");
    tx.rx_c0_rsp = 1'b1; step(); step(); step(); idle();
    @(negedge clk);
    chk("fence_q2", 64'(quiesced), 64'd0);
    step();
    @(negedge clk);
    chk("held_st", 64'(dut.state), 64'(ST_HELD));
    chk("held_q",  64'(quiesced), 64'd1);
    chk("held_drop", 64'(drop_cnt), 64'd2);

    // dual-channel drop while held adds 2
    drive_c0(42'h5, 16'h0005, M_FENCE);
    drive_c1(42'h5, 16'h0005, 64'h5, M_FENCE);
    step(); idle();
    @(negedge clk);
    check_model("held2");
    sub_afu_reset = 1'b0;
    step();
    @(negedge clk);
    chk("run_st", 64'(dut.state), 64'(ST_RUN));
    chk("run_q",  64'(quiesced), 64'd0);
    drive_c0(42'h6, 16'h0006, M_PASS); step(); idle();

    // c1 counter saturation
    for (int i = 0; i < 1024; i++) begin
      drive_c1(42'(i), 16'(i), 64'(i), M_PASS);
      step();
    end
    idle(); step();
    @(negedge clk);
    chk("sat_cnt1", 64'(dut.u_cnt_c1.count), 64'h3FF);
    check_model("sat");

    // bounds window
    reset = 1'b1; step(); reset = 1'b0;
    offset = 64'h40;
    drive_c0(42'(64'h1 << 30), 16'h0B0B, M_BND);
    step(); idle(); step(); step();
    @(negedge clk);
    check_model("bnd");

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
